// File: rtl/path_sequencer.sv
// path_sequencer: issues packed node paths from a writable table.
// Ports: clk, rst, wr_en/wr_idx/wr_path/wr_len, start, fi, new_path -> path_out, path_len, path_idx, flag_out, busy, done. Option: PATH_LOOP_EN.
module path_sequencer #(
  parameter int NODE_W    = 5,
  parameter int MAX_NODES = 14,
  parameter int NUM_PATHS = 4,
  localparam int PATH_W = NODE_W * MAX_NODES,
  localparam int IDX_W  = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1,
  localparam int LEN_W  = $clog2(MAX_NODES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [PATH_W-1:0] wr_path,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              start,
  input  logic              fi,
  input  logic              new_path,
  output logic [PATH_W-1:0] path_out,
  output logic [LEN_W-1:0]  path_len,
  output logic [IDX_W-1:0]  path_idx,
  output logic              flag_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  localparam logic [IDX_W:0] NP =
    (IDX_W + 1)'(NUM_PATHS);
  localparam logic [LEN_W-1:0] LMAX =
    LEN_W'(MAX_NODES);

  state_t state_q, state_d;

  logic [PATH_W-1:0] path_mem [NUM_PATHS];
  logic [LEN_W-1:0]  len_mem  [NUM_PATHS];

  logic              wr_ok;
  logic [LEN_W-1:0]  wr_len_c;
  logic [IDX_W:0]    nxt;
  logic [IDX_W-1:0]  nxt_idx;
  logic              load;
  logic [IDX_W-1:0]  load_idx;
  logic              flag_d;

  assign wr_ok    = wr_en && ({1'b0, wr_idx} < NP);
  assign wr_len_c = (wr_len > LMAX) ? LMAX : wr_len;
  assign nxt      = {1'b0, path_idx} + (IDX_W + 1)'(1);
  assign nxt_idx  = nxt[IDX_W-1:0];

  assign busy = (state_q == RUN) || (state_q == HOLD);
  assign done = (state_q == DONE);

  // Table: nonblocking writes, so an issue on the
  // same edge as a write sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PATHS; i++) begin
        path_mem[i] <= '0;
        len_mem[i]  <= '0;
      end
    end else if (wr_ok) begin
      path_mem[wr_idx] <= wr_path;
      len_mem[wr_idx]  <= wr_len_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      path_out <= '0;
      path_len <= '0;
      path_idx <= '0;
      flag_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      flag_out <= flag_d;
      if (load) begin
        path_out <= path_mem[load_idx];
        path_len <= len_mem[load_idx];
        path_idx <= load_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_idx = '0;
    flag_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (len_mem[0] != '0) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // fi wins; a coincident new_path is dropped
        if (fi) begin
          flag_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (new_path) begin
          if (nxt < NP) begin
            if (len_mem[nxt_idx] != '0) begin
              load     = 1'b1;
              load_idx = nxt_idx;
              state_d  = RUN;
            end else begin
              state_d = DONE;
            end
          end else begin
`ifdef PATH_LOOP_EN
            if (len_mem[0] != '0) begin
              load    = 1'b1;
              state_d = RUN;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_path_sequencer.sv
// tb_path_sequencer: directed bench for path_sequencer.
// Default build (PATH_LOOP_EN undefined).
module tb_path_sequencer;

  localparam int PW = 70;
  localparam int IW = 2;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [PW-1:0] wr_path;
  logic [LW-1:0] wr_len;
  logic          start;
  logic          fi;
  logic          new_path;
  logic [PW-1:0] path_out;
  logic [LW-1:0] path_len;
  logic [IW-1:0] path_idx;
  logic          flag_out;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [PW-1:0] E0 = {
    5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd4,
    5'd6, 5'd7, 5'd8, 5'd2, 5'd1, 5'd0, 5'd0};
  localparam logic [PW-1:0] E1 = {
    5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd9, 5'd8,
    5'd7, 5'd6, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
  localparam logic [PW-1:0] F2 = {14{5'd2}};
  localparam logic [PW-1:0] F3 = {14{5'd3}};
  localparam logic [PW-1:0] N1 = {14{5'd17}};
  localparam logic [PW-1:0] G2 = {14{5'd21}};

  path_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_path  (wr_path),
    .wr_len   (wr_len),
    .start    (start),
    .fi       (fi),
    .new_path (new_path),
    .path_out (path_out),
    .path_len (path_len),
    .path_idx (path_idx),
    .flag_out (flag_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [PW-1:0] obs,
                     input logic [PW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [IW-1:0] i,
                    input logic [PW-1:0] p,
                    input logic [LW-1:0] l);
    wr_en   = 1'b1;
    wr_idx  = i;
    wr_path = p;
    wr_len  = l;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_fi();
    fi = 1'b1;
    step();
    fi = 1'b0;
  endtask

  task automatic do_np();
    new_path = 1'b1;
    step();
    new_path = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_path  = '0;
    wr_len   = '0;
    start    = 1'b0;
    fi       = 1'b0;
    new_path = 1'b0;
    step();
    step();
    chk("rst_path", path_out, '0);
    chk("rst_len", PW'(path_len), '0);
    chk("rst_idx", PW'(path_idx), '0);
    chk("rst_flag", PW'(flag_out), '0);
    chk("rst_busy", PW'(busy), '0);
    chk("rst_done", PW'(done), '0);
    rst = 1'b0;

    do_start();
    chk("empty_done", PW'(done), PW'(1));
    chk("empty_busy", PW'(busy), '0);
    chk("empty_path", path_out, '0);

    wr(2'd0, E0, 4'd13);
    wr(2'd1, E1, 4'd10);
    do_start();
    chk("e0_path", path_out, E0);
    chk("e0_len", PW'(path_len), PW'(13));
    chk("e0_idx", PW'(path_idx), '0);
    chk("e0_busy", PW'(busy), PW'(1));
    chk("e0_done", PW'(done), '0);

    do_fi();
    chk("flag_hi", PW'(flag_out), PW'(1));
    step();
    chk("flag_lo", PW'(flag_out), '0);
    chk("hold_busy", PW'(busy), PW'(1));

    do_np();
    chk("e1_path", path_out, E1);
    chk("e1_idx", PW'(path_idx), PW'(1));
    chk("e1_len", PW'(path_len), PW'(10));

    wr(2'd2, F2, 4'd14);
    wr(2'd3, F3, 4'd14);

    fi       = 1'b1;
    new_path = 1'b1;
    step();
    fi       = 1'b0;
    new_path = 1'b0;
    chk("both_flag", PW'(flag_out), PW'(1));
    chk("both_idx", PW'(path_idx), PW'(1));
    chk("both_path", path_out, E1);

    do_np();
    chk("e2_idx", PW'(path_idx), PW'(2));
    chk("e2_path", path_out, F2);

    do_fi();
    do_np();
    chk("e3_idx", PW'(path_idx), PW'(3));
    chk("e3_path", path_out, F3);

    do_fi();
    do_np();
    chk("end_done", PW'(done), PW'(1));
    chk("end_busy", PW'(busy), '0);
    chk("end_idx", PW'(path_idx), PW'(3));
    chk("end_path", path_out, F3);

    do_start();
    chk("re_idx", PW'(path_idx), '0);
    do_fi();
    do_np();
    do_fi();
    wr(2'd1, N1, 4'd7);
    chk("hold_wr_path", path_out, E1);

    wr_en    = 1'b1;
    wr_idx   = 2'd2;
    wr_path  = G2;
    wr_len   = 4'd5;
    new_path = 1'b1;
    step();
    wr_en    = 1'b0;
    new_path = 1'b0;
    chk("rw_path", path_out, F2);
    chk("rw_len", PW'(path_len), PW'(14));
    chk("rw_idx", PW'(path_idx), PW'(2));

    do_start();
    chk("run_start_idx", PW'(path_idx), PW'(2));
    chk("run_start_path", path_out, F2);
    chk("run_start_busy", PW'(busy), PW'(1));

    do_fi();
    do_np();
    do_fi();
    do_np();
    chk("end2_done", PW'(done), PW'(1));
    do_start();
    do_fi();
    do_np();
    chk("new1_path", path_out, N1);
    chk("new1_len", PW'(path_len), PW'(7));

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_path", path_out, '0);
    chk("mid_rst_busy", PW'(busy), '0);
    chk("mid_rst_idx", PW'(path_idx), '0);
    chk("mid_rst_len", PW'(path_len), '0);

    do_start();
    chk("clr_done", PW'(done), PW'(1));

    wr(2'd0, E0, 4'd15);
    do_start();
    chk("clamp_path", path_out, E0);
    chk("clamp_len", PW'(path_len), PW'(14));
    chk("clamp_busy", PW'(busy), PW'(1));

    do_fi();
    do_np();
    chk("zero_done", PW'(done), PW'(1));
    chk("zero_idx", PW'(path_idx), '0);
    chk("zero_path", path_out, E0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
